// File: rtl/syn_gpu_pkg.sv
// Types shared by the blocks on the SRAM side of the GPU/VGA core.
// It holds the SRAM widths, the read-source tag and the command layout.
package syn_gpu_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic {SRAM_SRC_VGA, SRAM_SRC_GPU} sram_src_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wr_data;
  } sram_cmd_t;

endpackage

// File: rtl/syn_sram_arb_tag_fifo.sv
// In-order FIFO of read-source tags: one entry per read the SRAM driver has accepted.
// The head entry says which requester gets the next returned word.
module syn_sram_arb_tag_fifo
  import syn_gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk_ir,
  input  logic                    rst_sync,
  input  logic                    push,
  input  sram_src_t               push_src,
  input  logic                    pop,
  output sram_src_t               head_src,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  sram_src_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_src = mem[rd_ptr];

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_src;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/syn_sram_arb.sv
// Arbiter for the single SRAM command port: VGA (read-only, fixed priority) and GPU (read/write).
// A wait counter forces one GPU grant after GPU_MAX_WAIT cycles, and a tag FIFO steers read data back.
module syn_sram_arb
  import syn_gpu_pkg::sram_src_t, syn_gpu_pkg::SRAM_SRC_VGA, syn_gpu_pkg::SRAM_SRC_GPU;
#(
  parameter int SRAM_ADDR_W   = 18,
  parameter int SRAM_DATA_W   = 16,
  parameter int RD_FIFO_DEPTH = 8,
  parameter int GPU_MAX_WAIT  = 16
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync,
  input  logic                   vga_req,
  input  logic [SRAM_ADDR_W-1:0] vga_addr,
  output logic                   vga_ack,
  output logic                   vga_rd_valid,
  output logic [SRAM_DATA_W-1:0] vga_rd_data,
  input  logic                   gpu_req,
  input  logic                   gpu_we,
  input  logic [SRAM_ADDR_W-1:0] gpu_addr,
  input  logic [SRAM_DATA_W-1:0] gpu_wr_data,
  output logic                   gpu_ack,
  output logic                   gpu_rd_valid,
  output logic [SRAM_DATA_W-1:0] gpu_rd_data,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wr_data,
  input  logic                   sram_ready,
  input  logic                   sram_rd_valid,
  input  logic [SRAM_DATA_W-1:0] sram_rd_data,
  output logic                   rd_err
);

  localparam int CNT_W  = $clog2(RD_FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(GPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(RD_FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(GPU_MAX_WAIT);

  // Handshakes: a requester holds req and payload until ack, which pulses combinationally
  // in the grant cycle. On the driver side sram_req/payload hold until sram_ready is high.
  logic                   slot_valid;
  logic                   slot_we;
  logic [SRAM_ADDR_W-1:0] slot_addr;
  logic [SRAM_DATA_W-1:0] slot_wr_data;
  sram_src_t              slot_src;
  logic [WAIT_W-1:0]      wait_cnt;

  logic [CNT_W-1:0]       tag_count;
  logic                   tag_full;
  logic                   tag_empty;
  sram_src_t              tag_head;

  logic                   consume;
  logic                   slot_open;
  logic [CNT_W-1:0]       inflight;
  logic                   rd_room;
  logic                   vga_elig;
  logic                   gpu_elig;
  logic                   force_gpu;
  logic                   vga_win;
  logic                   gpu_win;
  logic                   tag_push;
  logic                   tag_pop;

  logic                   vga_rd_q;
  logic                   gpu_rd_q;
  logic [SRAM_DATA_W-1:0] rd_data_q;
  logic                   rd_err_q;

  assign consume   = slot_valid & sram_ready;
  assign slot_open = ~slot_valid | sram_ready;
  // Reads still sitting in the slot count against the FIFO so it can never overflow.
  assign inflight  = tag_count + CNT_W'(slot_valid & ~slot_we);
  assign rd_room   = (inflight < DEPTH_C);
  assign vga_elig  = ~rst_sync & vga_req & slot_open & rd_room;
  assign gpu_elig  = ~rst_sync & gpu_req & slot_open & (gpu_we | rd_room);
  assign force_gpu = (wait_cnt == WAIT_MAX_C);
  assign gpu_win   = gpu_elig & (~vga_elig | force_gpu);
  assign vga_win   = vga_elig & ~gpu_win;
  assign tag_push  = consume & ~slot_we & ~tag_full;
  assign tag_pop   = sram_rd_valid & ~tag_empty;

  assign vga_ack      = vga_win;
  assign gpu_ack      = gpu_win;
  assign sram_req     = slot_valid;
  assign sram_we      = slot_we;
  assign sram_addr    = slot_addr;
  assign sram_wr_data = slot_wr_data;
  assign vga_rd_valid = vga_rd_q;
  assign gpu_rd_valid = gpu_rd_q;
  assign vga_rd_data  = rd_data_q;
  assign gpu_rd_data  = rd_data_q;
  assign rd_err       = rd_err_q;

  syn_sram_arb_tag_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_ir   (clk_ir),
    .rst_sync (rst_sync),
    .push     (tag_push),
    .push_src (slot_src),
    .pop      (tag_pop),
    .head_src (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      slot_valid   <= 1'b0;
      slot_we      <= 1'b0;
      slot_addr    <= '0;
      slot_wr_data <= '0;
      slot_src     <= SRAM_SRC_VGA;
      wait_cnt     <= '0;
      vga_rd_q     <= 1'b0;
      gpu_rd_q     <= 1'b0;
      rd_data_q    <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      if (vga_win | gpu_win) begin
        slot_valid   <= 1'b1;
        slot_we      <= gpu_win & gpu_we;
        slot_addr    <= gpu_win ? gpu_addr : vga_addr;
        slot_wr_data <= gpu_win ? gpu_wr_data : '0;
        slot_src     <= gpu_win ? SRAM_SRC_GPU : SRAM_SRC_VGA;
      end else if (consume) begin
        slot_valid <= 1'b0;
      end

      if (!gpu_req || gpu_win) wait_cnt <= '0;
      else if (!force_gpu)     wait_cnt <= wait_cnt + 1'b1;

      vga_rd_q <= tag_pop & (tag_head == SRAM_SRC_VGA);
      gpu_rd_q <= tag_pop & (tag_head == SRAM_SRC_GPU);
      if (tag_pop) rd_data_q <= sram_rd_data;
      if (sram_rd_valid && tag_empty) rd_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_sram_arb.sv
// Directed bench for syn_sram_arb: grant latency, VGA priority with forced GPU grant,
// in-order read steering, FIFO back-pressure, orphan-return error and reset.
module tb_syn_sram_arb;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk_ir;
  logic          rst_sync;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ack;
  logic          vga_rd_valid;
  logic [DW-1:0] vga_rd_data;
  logic          gpu_req;
  logic          gpu_we;
  logic [AW-1:0] gpu_addr;
  logic [DW-1:0] gpu_wr_data;
  logic          gpu_ack;
  logic          gpu_rd_valid;
  logic [DW-1:0] gpu_rd_data;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wr_data;
  logic          sram_ready;
  logic          sram_rd_valid;
  logic [DW-1:0] sram_rd_data;
  logic          rd_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          src_q[$];

  syn_sram_arb #(
    .SRAM_ADDR_W   (AW),
    .SRAM_DATA_W   (DW),
    .RD_FIFO_DEPTH (8),
    .GPU_MAX_WAIT  (16)
  ) dut (
    .clk_ir        (clk_ir),
    .rst_sync      (rst_sync),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_ack       (vga_ack),
    .vga_rd_valid  (vga_rd_valid),
    .vga_rd_data   (vga_rd_data),
    .gpu_req       (gpu_req),
    .gpu_we        (gpu_we),
    .gpu_addr      (gpu_addr),
    .gpu_wr_data   (gpu_wr_data),
    .gpu_ack       (gpu_ack),
    .gpu_rd_valid  (gpu_rd_valid),
    .gpu_rd_data   (gpu_rd_data),
    .sram_req      (sram_req),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wr_data  (sram_wr_data),
    .sram_ready    (sram_ready),
    .sram_rd_valid (sram_rd_valid),
    .sram_rd_data  (sram_rd_data),
    .rd_err        (rd_err)
  );

  // Clock / reset
  initial clk_ir = 1'b0;
  always #5 clk_ir = ~clk_ir;

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic do_reset();
    rst_sync      = 1'b1;
    vga_req       = 1'b0;
    vga_addr      = '0;
    gpu_req       = 1'b0;
    gpu_we        = 1'b0;
    gpu_addr      = '0;
    gpu_wr_data   = '0;
    sram_ready    = 1'b1;
    sram_rd_valid = 1'b0;
    sram_rd_data  = '0;
    tick();
    tick();
    rst_sync = 1'b0;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({vga_ack, vga_rd_valid, vga_rd_data, gpu_ack, gpu_rd_valid, gpu_rd_data,
                 sram_req, sram_we, sram_addr, sram_wr_data, rd_err});
  endfunction

  initial begin
    logic [DW-1:0] ret_data [4];
    logic [AW-1:0] exp_addr [4];
    logic [DW-1:0] d;
    logic          s;

    do_reset();
    #1;
    check("reset_outputs", outs(), 128'd0);

    // Single VGA read, driver answers 3 cycles after issue
    vga_req = 1'b1; vga_addr = 18'h00100;
    #1;
    check("t1_vga_ack", vga_ack, 1'b1);
    check("t1_gpu_ack", gpu_ack, 1'b0);
    check("t1_no_early_req", sram_req, 1'b0);
    tick();
    vga_req = 1'b0;
    #1;
    check("t1_sram_req", sram_req, 1'b1);
    check("t1_sram_addr", sram_addr, 18'h00100);
    check("t1_sram_we", sram_we, 1'b0);
    tick();
    #1;
    check("t1_slot_drained", sram_req, 1'b0);
    tick();
    tick();
    sram_rd_valid = 1'b1; sram_rd_data = 16'hBEEF;
    #1;
    check("t1_rd_valid_not_early", vga_rd_valid, 1'b0);
    tick();
    sram_rd_valid = 1'b0; sram_rd_data = '0;
    #1;
    check("t1_vga_rd_valid", vga_rd_valid, 1'b1);
    check("t1_vga_rd_data", vga_rd_data, 16'hBEEF);
    check("t1_gpu_rd_valid", gpu_rd_valid, 1'b0);
    tick();
    #1;
    check("t1_vga_rd_pulse", vga_rd_valid, 1'b0);

    // Both request continuously: 16 VGA grants, then one forced GPU write grant
    do_reset();
    for (int c = 0; c < 34; c++) begin
      vga_req = 1'b1; vga_addr = 18'h00400;
      gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 18'h3FFFF; gpu_wr_data = 16'h55AA;
      sram_rd_valid = (c >= 2) && (((c - 2) % 17) != 16);
      sram_rd_data  = 16'(16'h1000 + c);
      #1;
      check("t2_vga_ack", vga_ack, (c % 17) != 16);
      check("t2_gpu_ack", gpu_ack, (c % 17) == 16);
      check("t2_vga_rd_valid", vga_rd_valid, (c >= 3) && (((c - 3) % 17) != 16));
      if ((c >= 3) && (((c - 3) % 17) != 16))
        check("t2_vga_rd_data", vga_rd_data, 16'(16'h1000 + c - 1));
      check("t2_gpu_rd_valid", gpu_rd_valid, 1'b0);
      tick();
    end

    // Interleaved V,G,V,G reads with 4-cycle driver latency
    do_reset();
    ret_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_addr = '{18'h00010, 18'h00020, 18'h00030, 18'h00040};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ret_data[i]);
      src_q.push_back(i % 2 == 1);
    end
    for (int c = 0; c < 11; c++) begin
      vga_req  = (c == 0) || (c == 2);
      vga_addr = (c == 0) ? 18'h00010 : 18'h00030;
      gpu_req  = (c == 1) || (c == 3);
      gpu_we   = 1'b0;
      gpu_addr = (c == 1) ? 18'h00020 : 18'h00040;
      sram_rd_valid = (c >= 5) && (c <= 8);
      sram_rd_data  = sram_rd_valid ? ret_data[(c - 5) & 3] : '0;
      #1;
      if (c < 4) begin
        check("t3_vga_ack", vga_ack, (c % 2) == 0);
        check("t3_gpu_ack", gpu_ack, (c % 2) == 1);
      end
      if ((c >= 1) && (c <= 4)) begin
        check("t3_sram_req", sram_req, 1'b1);
        check("t3_sram_addr", sram_addr, exp_addr[(c - 1) & 3]);
      end
      if (vga_rd_valid || gpu_rd_valid) begin
        if (exp_q.size() == 0) begin
          check("t3_extra_return", exp_q.size(), 32'd1);
        end else begin
          d = exp_q.pop_front();
          s = src_q.pop_front();
          check("t3_route", {vga_rd_valid, gpu_rd_valid}, s ? 2'b01 : 2'b10);
          check("t3_data", s ? gpu_rd_data : vga_rd_data, d);
        end
      end
      tick();
    end
    vga_req = 1'b0; gpu_req = 1'b0; sram_rd_valid = 1'b0;
    check("t3_all_returned", exp_q.size(), 32'd0);

    // Eight GPU reads outstanding: ninth read held off, write still granted
    do_reset();
    for (int c = 0; c < 8; c++) begin
      gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 18'(18'h00200 + c);
      #1;
      check("t4_read_ack", gpu_ack, 1'b1);
      tick();
    end
    gpu_req = 1'b0;
    tick();
    sram_ready = 1'b0;
    gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 18'h00300; gpu_wr_data = 16'h1234;
    #1;
    check("t4_write_ack", gpu_ack, 1'b1);
    tick();
    gpu_we = 1'b0; gpu_addr = 18'h00208; gpu_wr_data = '0;
    #1;
    check("t4_read9_blocked", gpu_ack, 1'b0);
    check("t4_write_cmd", {sram_req, sram_we, sram_addr, sram_wr_data},
          {1'b1, 1'b1, 18'h00300, 16'h1234});
    tick();
    sram_ready = 1'b1;
    #1;
    check("t4_read9_blocked_full", gpu_ack, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      check("t4_read9_still_blocked", gpu_ack, 1'b0);
      check("t4_no_cmd", sram_req, 1'b0);
    end
    tick();
    sram_rd_valid = 1'b1; sram_rd_data = 16'h5000;
    #1;
    check("t4_blocked_during_pop", gpu_ack, 1'b0);
    tick();
    sram_rd_valid = 1'b0; sram_rd_data = '0;
    #1;
    check("t4_read9_ack", gpu_ack, 1'b1);
    check("t4_gpu_rd_valid", gpu_rd_valid, 1'b1);
    check("t4_gpu_rd_data", gpu_rd_data, 16'h5000);
    check("t4_vga_rd_valid", vga_rd_valid, 1'b0);
    tick();
    gpu_req = 1'b0;
    #1;
    check("t4_read9_cmd", {sram_req, sram_we, sram_addr}, {1'b1, 1'b0, 18'h00208});

    // Orphan read return, then reset while a command is pending
    do_reset();
    sram_rd_valid = 1'b1; sram_rd_data = 16'hDEAD;
    #1;
    check("t5_err_clear", rd_err, 1'b0);
    tick();
    sram_rd_valid = 1'b0; sram_rd_data = '0;
    #1;
    check("t5_no_rd_valid", {vga_rd_valid, gpu_rd_valid}, 2'b00);
    check("t5_rd_err", rd_err, 1'b1);
    tick();
    #1;
    check("t5_rd_err_sticky", rd_err, 1'b1);
    tick();
    sram_ready = 1'b0;
    vga_req = 1'b1; vga_addr = 18'h003AB;
    #1;
    check("t5_vga_ack", vga_ack, 1'b1);
    tick();
    vga_req = 1'b0;
    rst_sync = 1'b1;
    #1;
    check("t5_pending_cmd", sram_req, 1'b1);
    tick();
    rst_sync = 1'b0;
    sram_ready = 1'b1;
    #1;
    check("t5_reset_outputs", outs(), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/syn_sram_arb.md
Name: syn_sram_arb

Overview:
- Arbitrates the single external SRAM command port between the VGA driver (read-only, real-time) and the GPU (read/write).
- Sits in the VCORTEX, between both requesters and the SRAM driver.
- VGA has fixed priority; an anti-starvation counter guarantees the GPU forward progress.
- In-order read returns are steered back to the issuing requester via a tag FIFO.

Parameters:
- SRAM_ADDR_W, 18, SRAM word address width.
- SRAM_DATA_W, 16, SRAM data width.
- RD_FIFO_DEPTH, 8, maximum in-flight reads (power of 2, >=2).
- GPU_MAX_WAIT, 16, cycles the GPU may wait before it gets one forced grant (>=1).

Ports:
- clk_ir  in  1  system clock
- rst_sync  in  1  synchronous reset, active-high
- vga_req  in  1  VGA read request
- vga_addr  in  SRAM_ADDR_W  VGA read address
- vga_ack  out  1  VGA request granted
- vga_rd_valid  out  1  VGA read data valid
- vga_rd_data  out  SRAM_DATA_W  VGA read data
- gpu_req  in  1  GPU request
- gpu_we  in  1  1=write, 0=read
- gpu_addr  in  SRAM_ADDR_W  GPU address
- gpu_wr_data  in  SRAM_DATA_W  GPU write data
- gpu_ack  out  1  GPU request granted
- gpu_rd_valid  out  1  GPU read data valid
- gpu_rd_data  out  SRAM_DATA_W  GPU read data
- sram_req  out  1  command valid to driver
- sram_we  out  1  command is write
- sram_addr  out  SRAM_ADDR_W  command address
- sram_wr_data  out  SRAM_DATA_W  command write data
- sram_ready  in  1  driver accepts command this cycle
- sram_rd_valid  in  1  driver read data valid (in issue order)
- sram_rd_data  in  SRAM_DATA_W  driver read data
- rd_err  out  1  sticky: read data returned with no outstanding tag

Behaviour:
- Reset:
  - All outputs are 0.
  - Command slot empty, tag FIFO empty, wait counter 0, rd_err cleared.
  - A reset mid-operation discards the pending slot and all tags.
- Request handshake:
  - The requester holds req and its payload stable until it sees ack.
  - ack is a combinational one-cycle pulse in the cycle of grant.
  - The requester may drop or change req the cycle after ack.
- Command slot (one-entry register holding sram_*):
  - The slot accepts a grant when it is empty, or when it is being consumed this cycle (sram_req & sram_ready).
  - The granted payload appears on sram_* in the next cycle (grant-to-sram_req latency = 1).
  - sram_req and payload hold until sram_ready=1.
  - Back-to-back grants sustain one command per cycle when sram_ready stays high.
- Grant eligibility:
  - The slot can accept.
  - For reads only: outstanding-read count plus slot-held reads is below RD_FIFO_DEPTH. Writes are never blocked by the FIFO.
- Priority:
  - VGA wins when both requesters are eligible.
  - Exception: wait_cnt==GPU_MAX_WAIT, in which case the GPU wins that grant.
- wait_cnt:
  - Increments each cycle gpu_req=1 and gpu_ack=0, saturating at GPU_MAX_WAIT.
  - Clears on gpu_ack or when gpu_req=0.
- Tag FIFO:
  - Pushes the source tag (VGA/GPU) when a read command is consumed by the driver.
  - Pops on sram_rd_valid.
  - Push and pop in the same cycle leave the count unchanged.
- Read return (registered, 1 cycle after sram_rd_valid):
  - The head tag selects which *_rd_valid pulses.
  - rd_data is driven to both requesters; only the selected valid asserts.
- Error: sram_rd_valid with the FIFO empty is dropped, sets rd_err (cleared only by reset), and no rd_valid pulses.
- Writes produce no response beyond gpu_ack.

Decomposition:
- Shared package syn_gpu_pkg holds:
  - SRAM_ADDR_W and SRAM_DATA_W constants.
  - typedef enum logic {SRAM_SRC_VGA, SRAM_SRC_GPU} sram_src_t.
  - Packed struct sram_cmd_t {we, addr, wr_data}.
- One sub-module, syn_sram_arb_tag_fifo: synchronous FIFO of sram_src_t, with push, pop, full, empty and count ports, and reset on rst_sync.

Test Plan:
- Single VGA read to 0x00100, driver returns 0xBEEF after 3 cycles -> vga_ack in cycle 0, sram_req with addr 0x00100 in cycle 1, vga_rd_valid with 0xBEEF one cycle after sram_rd_valid, gpu_rd_valid stays 0.
- VGA and GPU request continuously, sram_ready=1 -> VGA receives 16 consecutive grants, then exactly one gpu_ack on the 17th; pattern repeats.
- Interleaved reads V,G,V,G with 4-cycle driver latency -> returns routed in order to VGA,GPU,VGA,GPU with matching data and no cross-delivery.
- Stall sram_ready=0 while 8 GPU reads are outstanding and a 9th read is requested -> no ack until a return pops a tag; a GPU write is still granted meanwhile.
- Assert sram_rd_valid with no reads outstanding -> no rd_valid on either requester, rd_err=1 and held; rst_sync high for one cycle -> all outputs 0 on the next cycle.
